// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/result handshake bundle between control unit and seq_alu
interface seq_alu_if #(
   parameter int REGISTER_WIDTH = 8,
   parameter int OPCODE_WIDTH   = 4
);
   logic                      start;
   logic [OPCODE_WIDTH-1:0]   opCode;
   logic [REGISTER_WIDTH-1:0] registerValue;
   logic                      busy;
   logic                      done;
   logic [REGISTER_WIDTH-1:0] accumulator;
   logic                      carry;
   logic                      zero;

   modport master (
      output start, opCode, registerValue,
      input  busy, done, accumulator, carry, zero
   );

   modport slave (
      input  start, opCode, registerValue,
      output busy, done, accumulator, carry, zero
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - accumulator ALU with single-cycle ops and iterative shift/multiply
module seq_alu #(
   parameter int REGISTER_WIDTH = 8,
   parameter int OPCODE_WIDTH   = 4,
   parameter int SHAMT_WIDTH    = $clog2(REGISTER_WIDTH)
) (
   input logic      clock,
   input logic      reset,
   seq_alu_if.slave bus
);
   localparam int W  = REGISTER_WIDTH;
   localparam int CW = $clog2(REGISTER_WIDTH + 1);

   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_INC  = OPCODE_WIDTH'(7);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8);
   localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = OPCODE_WIDTH'(9);
   localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = OPCODE_WIDTH'(10);
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(11);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             shl_q, shl_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [2*W-1:0]   prod_next;
   logic [W:0]       sum, diff, inc;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic             upd_zero;

   // Arithmetic at W+1 bits: bit W is carry for add/inc and borrow for sub.
   assign sum   = {1'b0, acc_q} + {1'b0, bus.registerValue};
   assign diff  = {1'b0, acc_q} - {1'b0, bus.registerValue};
   assign inc   = {1'b0, acc_q} + {{W{1'b0}}, 1'b1};
   assign shamt = bus.registerValue[SHAMT_WIDTH-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         shl_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         shl_q    <= shl_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      shl_d     = shl_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      upd_zero  = 1'b0;
      prod_next = mplier_q[0] ? prod_q + mcand_q : prod_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               done_d   = 1'b1;
               upd_zero = 1'b1;
               case (bus.opCode)
                  OP_LOAD: begin acc_d = bus.registerValue;          carry_d = 1'b0;    end
                  OP_ADD:  begin acc_d = sum[W-1:0];                 carry_d = sum[W];  end
                  OP_SUB:  begin acc_d = diff[W-1:0];                carry_d = diff[W]; end
                  OP_XOR:  begin acc_d = acc_q ^ bus.registerValue;  carry_d = 1'b0;    end
                  OP_OR:   begin acc_d = acc_q | bus.registerValue;  carry_d = 1'b0;    end
                  OP_INC:  begin acc_d = inc[W-1:0];                 carry_d = inc[W];  end
                  OP_AND:  begin acc_d = acc_q & bus.registerValue;  carry_d = 1'b0;    end
                  OP_SHL, OP_SHR: begin
                     if (shamt == '0) begin
                        carry_d = 1'b0;
                     end else begin
                        done_d   = 1'b0;
                        upd_zero = 1'b0;
                        state_d  = S_SHIFT;
                        cnt_d    = CW'(shamt);
                        shl_d    = (bus.opCode == OP_SHL);
                     end
                  end
                  OP_MUL: begin
                     done_d   = 1'b0;
                     upd_zero = 1'b0;
                     state_d  = S_MUL;
                     cnt_d    = CW'(W);
                     mcand_d  = {{W{1'b0}}, acc_q};
                     mplier_d = bus.registerValue;
                     prod_d   = '0;
                  end
                  default: upd_zero = 1'b0;
               endcase
            end
         end
         S_SHIFT: begin
            if (shl_q) begin
               carry_d = acc_q[W-1];
               acc_d   = {acc_q[W-2:0], 1'b0};
            end else begin
               carry_d = acc_q[0];
               acc_d   = {1'b0, acc_q[W-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               upd_zero = 1'b1;
            end
         end
         S_MUL: begin
            // Accumulator stays put; the product only lands on the last iteration.
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               upd_zero = 1'b1;
               acc_d    = prod_next[W-1:0];
               carry_d  = |prod_next[2*W-1:W];
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (upd_zero) zero_d = (acc_d == '0);
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.accumulator = acc_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed and random checks of seq_alu against an arithmetic reference
module tb_seq_alu;
   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;

   seq_alu_if #(.REGISTER_WIDTH(W), .OPCODE_WIDTH(4)) bus ();

   seq_alu #(.REGISTER_WIDTH(W), .OPCODE_WIDTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int m_acc    = 0;
   int m_carry  = 0;
   int m_zero   = 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Called at a falling edge; issues one op and follows it to its done pulse.
   task automatic run_op(input int op, input int rv, input bit inject);
      int na, nc, nz, lat, k, s, p;
      bit upd;
      na = m_acc; nc = m_carry; nz = m_zero; lat = 1; upd = 1'b1; k = rv % W;
      case (op)
         1:  begin na = rv; nc = 0; end
         2:  begin s = m_acc + rv; na = s & MASK; nc = (s > MASK) ? 1 : 0; end
         3:  begin na = (m_acc - rv) & MASK; nc = (m_acc < rv) ? 1 : 0; end
         4:  begin na = m_acc ^ rv; nc = 0; end
         6:  begin na = m_acc | rv; nc = 0; end
         7:  begin s = m_acc + 1; na = s & MASK; nc = (s > MASK) ? 1 : 0; end
         8:  begin na = m_acc & rv; nc = 0; end
         9:  begin
                nc = (k == 0) ? 0 : ((m_acc >> (W - k)) & 1);
                na = (m_acc << k) & MASK;
                lat = k + 1;
             end
         10: begin
                nc = (k == 0) ? 0 : ((m_acc >> (k - 1)) & 1);
                na = m_acc >> k;
                lat = k + 1;
             end
         11: begin
                p = m_acc * rv;
                na = p & MASK;
                nc = ((p >> W) != 0) ? 1 : 0;
                lat = W + 1;
             end
         default: upd = 1'b0;
      endcase
      if (upd) nz = (na == 0) ? 1 : 0;

      bus.start = 1'b1;
      bus.opCode = op[3:0];
      bus.registerValue = rv[7:0];
      for (int c = 1; c <= lat; c++) begin
         tick();
         bus.start = inject && (c == 3);
         if (bus.start) begin
            bus.opCode = 4'd1;
            bus.registerValue = 8'hAA;
         end
         if (c < lat) begin
            chk($sformatf("busy op%0d c%0d", op, c), int'(bus.busy), 1);
            chk($sformatf("done_early op%0d c%0d", op, c), int'(bus.done), 0);
            if (op == 11) chk($sformatf("mul_hold c%0d", c), 32'(bus.accumulator), m_acc);
         end else begin
            chk($sformatf("done op%0d", op), int'(bus.done), 1);
            chk($sformatf("busy_end op%0d", op), int'(bus.busy), 0);
            chk($sformatf("acc op%0d rv%0h", op, rv), 32'(bus.accumulator), na);
            chk($sformatf("carry op%0d rv%0h", op, rv), int'(bus.carry), nc);
            chk($sformatf("zero op%0d rv%0h", op, rv), int'(bus.zero), nz);
         end
      end
      bus.start = 1'b0;
      m_acc = na; m_carry = nc; m_zero = nz;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.opCode = 4'd0;
      bus.registerValue = 8'd0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_acc", 32'(bus.accumulator), 0);
      chk("rst_carry", int'(bus.carry), 0);
      chk("rst_zero", int'(bus.zero), 1);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      reset = 1'b0;
      tick();

      run_op(1, 'hF0, 1'b0);
      tick();
      chk("done_one_cycle", int'(bus.done), 0);
      run_op(2, 'h20, 1'b0);
      run_op(3, 'h10, 1'b0);
      run_op(3, 'h01, 1'b0);
      run_op(1, 'hF3, 1'b0);
      run_op(8, 'h0F, 1'b0);
      run_op(5, 'h3C, 1'b0);
      run_op(1, 'h81, 1'b0);
      run_op(9, 3, 1'b0);
      run_op(1, 'h81, 1'b0);
      run_op(10, 1, 1'b0);
      run_op(9, 'h10, 1'b0);
      tick();
      chk("done_after_shl0", int'(bus.done), 0);
      run_op(1, 'h10, 1'b0);
      run_op(11, 'h11, 1'b1);
      run_op(1, 'h03, 1'b0);
      run_op(11, 'h05, 1'b0);
      run_op(7, 0, 1'b0);

      // Reset in cycle N+4 of a multiply.
      run_op(1, 'h77, 1'b0);
      bus.start = 1'b1;
      bus.opCode = 4'd11;
      bus.registerValue = 8'h33;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      chk("mul_busy_pre_reset", int'(bus.busy), 1);
      reset = 1'b1;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_acc", 32'(bus.accumulator), 0);
      chk("arst_zero", int'(bus.zero), 1);
      chk("arst_carry", int'(bus.carry), 0);
      chk("arst_done", int'(bus.done), 0);
      m_acc = 0; m_carry = 0; m_zero = 1;
      tick();
      reset = 1'b0;
      tick();
      chk("post_reset_idle", int'(bus.busy), 0);
      run_op(1, 'h55, 1'b0);

      for (int i = 0; i < 60; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
